// File: rtl/acs_pkg.sv
// acs_pkg: shared constants, FSM encoding and trellis helpers for the
// K=3, rate-1/2 (7/5 octal) add-compare-select sequencer.
//   NUM_ST   - trellis states
//   PM_W     - path-metric width
//   NSLOT    - adder slots per trellis step (two candidates per state)
//   PM_RESET - packed reset metrics, state j at [PM_W*j +: PM_W]
//   pred     - predecessor x of next state j
//   exp_bits - expected {c1,c0} on edge p -> j
package acs_pkg;

  localparam int NUM_ST = 4;
  localparam int PM_W   = 6;
  localparam int NSLOT  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    OUT
  } acs_state_t;

  // State 0 starts as the known origin; all others are equally unlikely.
  localparam logic [NUM_ST*PM_W-1:0] PM_RESET = {6'd16, 6'd16, 6'd16, 6'd0};

  // State s = {s1,s0}, s1 being the most recent input bit.
  // Next state j = {u,s1}, so the predecessors of j are {j[0], x}.
  function automatic logic [1:0] pred(input logic [1:0] j, input logic x);
    return {j[0], x};
  endfunction

  // Generators 7 (c0 = u^s1^s0) and 5 (c1 = u^s0), with u = j[1].
  function automatic logic [1:0] exp_bits(input logic [1:0] p, input logic [1:0] j);
    logic c0;
    logic c1;
    c0 = j[1] ^ p[1] ^ p[0];
    c1 = j[1] ^ p[0];
    return {c1, c0};
  endfunction

endpackage

// File: rtl/acs_scheduler_branch_metric.sv
// branch_metric_calc: combinational hard-decision branch metric.
//   in_sym - received code bits {c1,c0}
//   p      - predecessor state of the edge
//   j      - next state of the edge
//   bm     - Hamming distance (0..2), zero-extended to PM_W bits
module branch_metric_calc
  import acs_pkg::*;
(
  input  logic [1:0]      in_sym,
  input  logic [1:0]      p,
  input  logic [1:0]      j,
  output logic [PM_W-1:0] bm
);

  logic [1:0] w_exp;
  logic [1:0] w_diff;

  always_comb begin
    w_exp  = exp_bits(p, j);
    w_diff = in_sym ^ w_exp;
    // Two-bit popcount: carry = both differ, sum = exactly one differs.
    bm     = {{(PM_W-2){1'b0}}, w_diff[1] & w_diff[0], w_diff[1] ^ w_diff[0]};
  end

endmodule

// File: rtl/acs_scheduler.sv
// acs_scheduler: sequences one Viterbi path-metric update per received
// symbol through a single shared external 6-bit adder.
//   clk, rst_n          - rising-edge clock, async active-low reset
//   in_valid/in_ready   - symbol handshake, in_sym = {c1,c0}
//   load_en/load_pm     - preload path metrics (IDLE only)
//   add_en/add_a/add_b  - shared adder request and operands (0 when idle)
//   add_s               - adder sum, combinational in the same cycle
//   out_valid/out_ready - result handshake
//   pm_out              - committed metrics, state j at [6j+5:6j]
//   surv                - survivor bit per state (1 = predecessor 1)
module acs_scheduler
  import acs_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_sym,
  input  logic                   load_en,
  input  logic [NUM_ST*PM_W-1:0] load_pm,
  output logic                   add_en,
  output logic [PM_W-1:0]        add_a,
  output logic [PM_W-1:0]        add_b,
  input  logic [PM_W-1:0]        add_s,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_ST*PM_W-1:0] pm_out,
  output logic [NUM_ST-1:0]      surv
);

  acs_state_t r_state;
  acs_state_t w_state_nxt;

  logic [2:0]                     r_slot;
  logic [1:0]                     r_sym;
  logic [NUM_ST*PM_W-1:0]         r_pm;
  logic [NUM_ST-1:0]              r_surv;
  logic [PM_W-1:0]                r_cand0;
  // Staging for states 0..2; state 3 resolves in slot 7 and commits directly.
  logic [(NUM_ST-1)*PM_W-1:0]     r_new_pm;
  logic [NUM_ST-2:0]              r_new_surv;

  logic [1:0]                     w_j;
  logic [1:0]                     w_p;
  logic [PM_W-1:0]                w_bm;
  logic                           w_take1;
  logic [PM_W-1:0]                w_sel;
  logic                           w_accept;
  logic                           w_commit;
  logic                           w_all_hi;
  logic [NUM_ST*PM_W-1:0]         w_pm_final;
  logic [NUM_ST-1:0]              w_surv_final;

  // Slot k handles next state k>>1 via predecessor k[0].
  assign w_j = r_slot[2:1];
  assign w_p = pred(w_j, r_slot[0]);

  branch_metric_calc u_bm (
    .in_sym (r_sym),
    .p      (w_p),
    .j      (w_j),
    .bm     (w_bm)
  );

  // Strict less-than so ties keep predecessor 0.
  assign w_take1  = (add_s < r_cand0);
  assign w_sel    = w_take1 ? add_s : r_cand0;
  assign w_accept = (r_state == IDLE) && in_valid && !load_en;
  assign w_commit = (r_state == ADD) && (r_slot == 3'd7);

  always_comb begin
    w_pm_final   = {w_sel, r_new_pm};
    w_surv_final = {w_take1, r_new_surv};
    w_all_hi     = 1'b1;
    for (int unsigned i = 0; i < NUM_ST; i++) begin
      w_all_hi = w_all_hi & w_pm_final[PM_W*i + PM_W-1];
    end
    // Subtracting 32 from every metric preserves their ordering and keeps
    // every later sum (metric + at most 2) inside 6 bits.
    if (w_all_hi) begin
      for (int unsigned i = 0; i < NUM_ST; i++) begin
        w_pm_final[PM_W*i + PM_W-1] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    add_en      = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !load_en;
        if (w_accept) begin
          w_state_nxt = ADD;
        end
      end
      ADD: begin
        add_en = 1'b1;
        if (r_slot == 3'd7) begin
          w_state_nxt = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign add_a = add_en ? r_pm[PM_W*w_p +: PM_W] : '0;
  assign add_b = add_en ? w_bm : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot     <= '0;
      r_sym      <= '0;
      r_pm       <= PM_RESET;
      r_surv     <= '0;
      r_cand0    <= '0;
      r_new_pm   <= '0;
      r_new_surv <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load_en) begin
            r_pm <= load_pm;
          end else if (in_valid) begin
            r_sym  <= in_sym;
            r_slot <= '0;
          end
        end
        ADD: begin
          r_slot <= r_slot + 3'd1;
          if (!r_slot[0]) begin
            r_cand0 <= add_s;
          end else if (!w_commit) begin
            r_new_pm[PM_W*w_j +: PM_W] <= w_sel;
            r_new_surv[w_j]            <= w_take1;
          end
          if (w_commit) begin
            r_pm   <= w_pm_final;
            r_surv <= w_surv_final;
          end
        end
        default: ;
      endcase
    end
  end

  assign pm_out = r_pm;
  assign surv   = r_surv;

endmodule

// File: tb/tb_acs_scheduler.sv
module tb_acs_scheduler;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sym;
  logic        load_en;
  logic [23:0] load_pm;
  logic        add_en;
  logic [5:0]  add_a;
  logic [5:0]  add_b;
  logic [5:0]  add_s;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] pm_out;
  logic [3:0]  surv;

  int total;
  int bad;

  acs_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sym    (in_sym),
    .load_en   (load_en),
    .load_pm   (load_pm),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pm_out    (pm_out),
    .surv      (surv)
  );

  // External shared adder: plain 6-bit combinational sum.
  assign add_s = add_a + add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sym    = 2'b00;
    load_en   = 1'b0;
    load_pm   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [23:0] v);
    load_en = 1'b1;
    load_pm = v;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Offers a symbol in IDLE, counts add_en cycles until out_valid (bounded).
  task automatic send_sym(input logic [1:0] sym, output int adds, output bit seen);
    in_sym   = sym;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    adds = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (add_en) adds++;
      @(posedge clk); #1;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (pm_out !== {6'd16, 6'd16, 6'd16, 6'd0}) begin bad++; $display("FAIL reset_pm got=%h want=%h", pm_out, {6'd16, 6'd16, 6'd16, 6'd0}); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (add_en !== 1'b0 || add_a !== 6'd0 || add_b !== 6'd0) begin bad++; $display("FAIL reset_adder got=%b/%0d/%0d want=0/0/0", add_en, add_a, add_b); end
    total++; if (surv !== 4'b0000) begin bad++; $display("FAIL reset_surv got=%b want=0000", surv); end
  endtask

  task automatic test_sym00();
    int adds; bit seen;
    apply_reset();
    send_sym(2'b00, adds, seen);
    total++; if (!seen) begin bad++; $display("FAIL sym00_timeout got=no out_valid want=out_valid"); end
    total++; if (adds !== 8) begin bad++; $display("FAIL sym00_add_cycles got=%0d want=8", adds); end
    total++; if (pm_out !== {6'd17, 6'd2, 6'd17, 6'd0}) begin bad++; $display("FAIL sym00_pm got=%h want=%h", pm_out, {6'd17, 6'd2, 6'd17, 6'd0}); end
    total++; if (surv !== 4'b0000) begin bad++; $display("FAIL sym00_surv got=%b want=0000", surv); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sym00_in_ready_out got=%b want=0", in_ready); end
    handshake();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL sym00_return got=%b/%b want=1/0", in_ready, out_valid); end
  endtask

  task automatic test_sym11();
    int adds; bit seen;
    apply_reset();
    send_sym(2'b11, adds, seen);
    total++; if (!seen || adds !== 8) begin bad++; $display("FAIL sym11_timing got=%0d/%b want=8/1", adds, seen); end
    total++; if (pm_out !== {6'd17, 6'd0, 6'd17, 6'd2}) begin bad++; $display("FAIL sym11_pm got=%h want=%h", pm_out, {6'd17, 6'd0, 6'd17, 6'd2}); end
    total++; if (surv !== 4'b0000) begin bad++; $display("FAIL sym11_surv got=%b want=0000", surv); end
    handshake();
  endtask

  task automatic test_load();
    int adds; bit seen;
    apply_reset();
    load_en = 1'b1;
    load_pm = {6'd0, 6'd0, 6'd3, 6'd10};
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL load_in_ready got=%b want=0", in_ready); end
    @(posedge clk); #1;
    load_en = 1'b0;
    total++; if (pm_out !== {6'd0, 6'd0, 6'd3, 6'd10}) begin bad++; $display("FAIL load_pm got=%h want=%h", pm_out, {6'd0, 6'd0, 6'd3, 6'd10}); end
    send_sym(2'b00, adds, seen);
    total++; if (!seen || adds !== 8) begin bad++; $display("FAIL load_timing got=%0d/%b want=8/1", adds, seen); end
    total++; if (pm_out !== {6'd1, 6'd3, 6'd1, 6'd5}) begin bad++; $display("FAIL load_step_pm got=%h want=%h", pm_out, {6'd1, 6'd3, 6'd1, 6'd5}); end
    total++; if (surv !== 4'b0101) begin bad++; $display("FAIL load_step_surv got=%b want=0101", surv); end
    handshake();
  endtask

  task automatic test_normalise();
    int adds; bit seen;
    apply_reset();
    do_load({6'd40, 6'd40, 6'd40, 6'd40});
    send_sym(2'b00, adds, seen);
    total++; if (!seen || adds !== 8) begin bad++; $display("FAIL norm_timing got=%0d/%b want=8/1", adds, seen); end
    total++; if (pm_out !== {6'd9, 6'd8, 6'd9, 6'd8}) begin bad++; $display("FAIL norm_pm got=%h want=%h", pm_out, {6'd9, 6'd8, 6'd9, 6'd8}); end
    total++; if (surv !== 4'b0100) begin bad++; $display("FAIL norm_surv got=%b want=0100", surv); end
    handshake();
  endtask

  // Continues from the normalised metrics {8,9,8,9} without reset.
  task automatic test_back_to_back();
    int adds; bit seen;
    send_sym(2'b00, adds, seen);
    total++; if (!seen || adds !== 8) begin bad++; $display("FAIL b2b_timing got=%0d/%b want=8/1", adds, seen); end
    total++; if (pm_out !== {6'd9, 6'd9, 6'd9, 6'd8}) begin bad++; $display("FAIL b2b_pm got=%h want=%h", pm_out, {6'd9, 6'd9, 6'd9, 6'd8}); end
    total++; if (surv !== 4'b0100) begin bad++; $display("FAIL b2b_surv got=%b want=0100", surv); end
  endtask

  // Still in OUT from test_back_to_back; stray load/in_valid must be ignored.
  task automatic test_backpressure();
    load_en  = 1'b1;
    load_pm  = {6'd33, 6'd33, 6'd33, 6'd33};
    in_valid = 1'b1;
    in_sym   = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || add_en !== 1'b0) begin bad++; $display("FAIL bp_ctrl cyc=%0d got=%b/%b/%b want=1/0/0", c, out_valid, in_ready, add_en); end
      total++; if (pm_out !== {6'd9, 6'd9, 6'd9, 6'd8} || surv !== 4'b0100) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h/%b want=%h/0100", c, pm_out, surv, {6'd9, 6'd9, 6'd9, 6'd8}); end
    end
    load_en  = 1'b0;
    in_valid = 1'b0;
    handshake();
    total++; if (in_ready !== 1'b1 || pm_out !== {6'd9, 6'd9, 6'd9, 6'd8}) begin bad++; $display("FAIL bp_release got=%b/%h want=1/%h", in_ready, pm_out, {6'd9, 6'd9, 6'd9, 6'd8}); end
  endtask

  task automatic test_reset_mid_add();
    logic [5:0] exp_b [4];
    exp_b[0] = 6'd2; exp_b[1] = 6'd0; exp_b[2] = 6'd1; exp_b[3] = 6'd1;
    apply_reset();
    do_load({6'd40, 6'd40, 6'd40, 6'd40});
    in_sym   = 2'b11;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (add_en !== 1'b1 || add_a !== 6'd40 || add_b !== exp_b[k]) begin bad++; $display("FAIL mid_slot%0d got=%b/%0d/%0d want=1/40/%0d", k, add_en, add_a, add_b, exp_b[k]); end
      if (k < 3) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0;
    #1;
    total++; if (pm_out !== {6'd16, 6'd16, 6'd16, 6'd0} || add_en !== 1'b0 || add_a !== 6'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset got=%h/%b/%0d/%b want=%h/0/0/0", pm_out, add_en, add_a, out_valid, {6'd16, 6'd16, 6'd16, 6'd0}); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0 || add_en !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_after cyc=%0d got=%b/%b/%b want=0/0/1", c, out_valid, add_en, in_ready); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sym00();
    test_sym11();
    test_load();
    test_normalise();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_add();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
